// File: rtl/vlane_mem_unit_pkg.sv
// Shared vector package for the lane memory unit.
// Contents:
//   vmu_state_e         - load/store unit FSM states
//   vmu_req_t           - captured request (we, addr, wdata, dest)
//   vrf_wb_t            - VRF write-back bundle
//   to_vector_execution - builds a write-back bundle, zeroed when not strobing
// Struct field widths are fixed at the lane defaults; the unit's parameters
// must not exceed VMU_DATA_W / VMU_ADDR_W.
package vlane_mem_unit_pkg;

  localparam int VMU_DATA_W = 64;
  localparam int VMU_ADDR_W = 32;
  localparam int VRF_ADDR_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    WB,
    SDONE
  } vmu_state_e;

  typedef struct packed {
    logic                  we;
    logic [VMU_ADDR_W-1:0] addr;
    logic [VMU_DATA_W-1:0] wdata;
    logic [VRF_ADDR_W-1:0] dest;
  } vmu_req_t;

  typedef struct packed {
    logic                  strobe;
    logic [VRF_ADDR_W-1:0] dest;
    logic [VMU_DATA_W-1:0] data;
  } vrf_wb_t;

  function automatic vrf_wb_t to_vector_execution(
    input logic                  strobe,
    input logic [VRF_ADDR_W-1:0] dest,
    input logic [VMU_DATA_W-1:0] data
  );
    vrf_wb_t wb;
    wb.strobe = strobe;
    wb.dest   = strobe ? dest : '0;
    wb.data   = strobe ? data : '0;
    return wb;
  endfunction

endpackage

// File: rtl/vlane_mem_unit_agu.sv
// vmu_agu: combinational lane address generator.
// addr = base_addr + (indexed_op ? index : stride_offset), carry dropped.
// Ports:
//   indexed_op    in   select index (1) or stride_offset (0) as offset
//   base_addr     in   scalar base address
//   stride_offset in   unit-stride / strided lane offset
//   index         in   per-element index, already truncated to ADDR_WIDTH
//   addr          out  generated address
module vmu_agu
  import vlane_mem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = VMU_ADDR_W
) (
  input  logic                  indexed_op,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride_offset,
  input  logic [ADDR_WIDTH-1:0] index,
  output logic [ADDR_WIDTH-1:0] addr
);

  assign addr = base_addr + (indexed_op ? index : stride_offset);

endmodule

// File: rtl/vlane_mem_unit.sv
// vlane_mem_unit: per-lane vector load/store unit.
// Captures one load or store from issue, performs a single valid/ready
// request on the lane memory port, and returns load data to the VRF.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   ld_valid, st_valid          load / store request from issue
//   indexed_op                  use indexed (else stride_offset) as offset
//   ld_destination              load destination vector register
//   wrdata, indexed             store data, index operand
//   base_addr, stride_offset    address operands
//   busy                        unit not idle
//   mem_req_*                   memory request channel (valid/ready)
//   mem_resp_valid/rdata        load response
//   read_done, load_data_destination, data_from_load   VRF write-back
//   st_done                     store-complete pulse
//   protocol_err                sticky: ld_valid and st_valid together
// All outputs come from registers or are decoded from state.
module vlane_mem_unit
  import vlane_mem_unit_pkg::*;
#(
  parameter int LANES_DATA_WIDTH = VMU_DATA_W,
  parameter int ADDR_WIDTH       = VMU_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_valid,
  input  logic                        st_valid,
  input  logic                        indexed_op,
  input  logic [4:0]                  ld_destination,
  input  logic [LANES_DATA_WIDTH-1:0] wrdata,
  input  logic [LANES_DATA_WIDTH-1:0] indexed,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [ADDR_WIDTH-1:0]       stride_offset,
  output logic                        busy,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_we,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr,
  output logic [LANES_DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                        mem_resp_valid,
  input  logic [LANES_DATA_WIDTH-1:0] mem_resp_rdata,
  output logic                        read_done,
  output logic [4:0]                  load_data_destination,
  output logic [LANES_DATA_WIDTH-1:0] data_from_load,
  output logic                        st_done,
  output logic                        protocol_err
);

  vmu_state_e                  state, state_next;
  vmu_req_t                    req;
  logic [LANES_DATA_WIDTH-1:0] load_data;
  logic [ADDR_WIDTH-1:0]       agu_addr;
  logic                        capture;
  vrf_wb_t                     wb;

  // Only the low ADDR_WIDTH bits of the index take part in addressing.
  if (LANES_DATA_WIDTH > ADDR_WIDTH) begin : g_idx_hi
    logic unused_index_hi;
    assign unused_index_hi = ^indexed[LANES_DATA_WIDTH-1:ADDR_WIDTH];
  end

  vmu_agu #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_agu (
    .indexed_op   (indexed_op),
    .base_addr    (base_addr),
    .stride_offset(stride_offset),
    .index        (indexed[ADDR_WIDTH-1:0]),
    .addr         (agu_addr)
  );

  assign capture = (state == IDLE) && (ld_valid || st_valid);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (ld_valid || st_valid) state_next = REQ;
      REQ:     if (mem_req_ready) state_next = req.we ? SDONE : RESP;
      RESP:    if (mem_resp_valid) state_next = WB;
      WB:      state_next = IDLE;
      SDONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, load data capture and sticky protocol error.
  // A simultaneous ld/st is executed as a load, so we requires !ld_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req          <= '0;
      load_data    <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (capture) begin
        req.we    <= st_valid && !ld_valid;
        req.addr  <= VMU_ADDR_W'(agu_addr);
        req.wdata <= (st_valid && !ld_valid) ? VMU_DATA_W'(wrdata) : '0;
        req.dest  <= ld_destination;
        if (ld_valid && st_valid) protocol_err <= 1'b1;
      end
      if ((state == RESP) && mem_resp_valid) load_data <= mem_resp_rdata;
    end
  end

  // Output decode
  always_comb begin
    busy          = (state != IDLE);
    mem_req_valid = (state == REQ);
    mem_req_we    = (state == REQ) && req.we;
    mem_req_addr  = (state == REQ) ? ADDR_WIDTH'(req.addr) : '0;
    mem_req_wdata = (state == REQ) ? LANES_DATA_WIDTH'(req.wdata) : '0;
    st_done       = (state == SDONE);
    wb            = to_vector_execution(state == WB, req.dest, VMU_DATA_W'(load_data));
    read_done             = wb.strobe;
    load_data_destination = wb.dest;
    data_from_load        = LANES_DATA_WIDTH'(wb.data);
  end

endmodule

// File: tb/tb_vlane_mem_unit.sv
// Self-checking bench for vlane_mem_unit: directed vector table, hand-written
// reset/stray-response/busy-ignore sequences, and a randomized phase whose
// expectations come from a small transaction-level model.
module tb_vlane_mem_unit;

  localparam int DW = 64;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid, st_valid, indexed_op;
  logic [4:0]    ld_destination;
  logic [DW-1:0] wrdata, indexed;
  logic [AW-1:0] base_addr, stride_offset;
  logic          busy, mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_rdata;
  logic          read_done;
  logic [4:0]    load_data_destination;
  logic [DW-1:0] data_from_load;
  logic          st_done, protocol_err;

  always #5 clk = ~clk;

  vlane_mem_unit #(
    .LANES_DATA_WIDTH(DW),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ld_valid             (ld_valid),
    .st_valid             (st_valid),
    .indexed_op           (indexed_op),
    .ld_destination       (ld_destination),
    .wrdata               (wrdata),
    .indexed              (indexed),
    .base_addr            (base_addr),
    .stride_offset        (stride_offset),
    .busy                 (busy),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req_we           (mem_req_we),
    .mem_req_addr         (mem_req_addr),
    .mem_req_wdata        (mem_req_wdata),
    .mem_resp_valid       (mem_resp_valid),
    .mem_resp_rdata       (mem_resp_rdata),
    .read_done            (read_done),
    .load_data_destination(load_data_destination),
    .data_from_load       (data_from_load),
    .st_done              (st_done),
    .protocol_err         (protocol_err)
  );

  typedef struct {
    logic          ld, st, idx_op;
    logic [4:0]    dest;
    logic [DW-1:0] wd, idx;
    logic [AW-1:0] base, stride;
    int unsigned   rdy_dly, resp_dly;
    logic [DW-1:0] rdata;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic          exp_perr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic m_perr = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic exp_perr);
    check({tag, " busy"}, DW'(busy), '0);
    check({tag, " req_valid"}, DW'(mem_req_valid), '0);
    check({tag, " req_we"}, DW'(mem_req_we), '0);
    check({tag, " read_done"}, DW'(read_done), '0);
    check({tag, " st_done"}, DW'(st_done), '0);
    check({tag, " wb_dest"}, DW'(load_data_destination), '0);
    check({tag, " wb_data"}, data_from_load, '0);
    check({tag, " perr"}, DW'(protocol_err), DW'(exp_perr));
  endtask

  // Operand inputs are don't-care while busy; randomize them to prove the
  // request is held from captured state. noise: 0 idle, 1 ld/st forced, 2 random.
  task automatic scramble(input int noise);
    wrdata         = {$urandom, $urandom};
    indexed        = {$urandom, $urandom};
    base_addr      = $urandom;
    stride_offset  = $urandom;
    ld_destination = 5'($urandom);
    indexed_op     = 1'($urandom);
    ld_valid       = (noise == 1) ? 1'b1 : (noise == 2) ? 1'($urandom) : 1'b0;
    st_valid       = (noise == 1) ? 1'b1 : (noise == 2) ? 1'($urandom) : 1'b0;
  endtask

  // One full transaction from an IDLE cycle, checked cycle by cycle.
  task automatic do_op(input vec_t v, input int noise);
    logic [DW-1:0] exp_wd;
    exp_wd         = v.exp_we ? v.wd : '0;
    ld_valid       = v.ld;
    st_valid       = v.st;
    indexed_op     = v.idx_op;
    ld_destination = v.dest;
    wrdata         = v.wd;
    indexed        = v.idx;
    base_addr      = v.base;
    stride_offset  = v.stride;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    tick();
    for (int unsigned i = 0; i <= v.rdy_dly; i++) begin
      check("req valid", DW'(mem_req_valid), 1);
      check("req addr", DW'(mem_req_addr), DW'(v.exp_addr));
      check("req we", DW'(mem_req_we), DW'(v.exp_we));
      check("req wdata", mem_req_wdata, exp_wd);
      check("req busy", DW'(busy), 1);
      check("req perr", DW'(protocol_err), DW'(v.exp_perr));
      scramble(noise);
      mem_resp_valid = (noise != 0) ? 1'($urandom) : 1'b0;
      mem_req_ready  = (i == v.rdy_dly);
      tick();
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    if (v.exp_we) begin
      check("st_done", DW'(st_done), 1);
      check("sdone busy", DW'(busy), 1);
      check("sdone req_valid", DW'(mem_req_valid), 0);
      check("sdone read_done", DW'(read_done), 0);
      scramble(noise);
      tick();
    end else begin
      for (int unsigned i = 0; i <= v.resp_dly; i++) begin
        check("resp busy", DW'(busy), 1);
        check("resp req_valid", DW'(mem_req_valid), 0);
        check("resp read_done", DW'(read_done), 0);
        check("resp st_done", DW'(st_done), 0);
        scramble(noise);
        mem_req_ready  = (noise != 0) ? 1'($urandom) : 1'b0;
        mem_resp_valid = (i == v.resp_dly);
        mem_resp_rdata = (i == v.resp_dly) ? v.rdata : {$urandom, $urandom};
        tick();
      end
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_rdata = {$urandom, $urandom};
      check("read_done", DW'(read_done), 1);
      check("wb dest", DW'(load_data_destination), DW'(v.dest));
      check("wb data", data_from_load, v.rdata);
      check("wb busy", DW'(busy), 1);
      check("wb st_done", DW'(st_done), 0);
      scramble(noise);
      tick();
    end
    ld_valid = 1'b0;
    st_valid = 1'b0;
    check_quiet("post-op", v.exp_perr);
  endtask

  function automatic vec_t mkvec(
    input logic ld, st, idx_op, input logic [4:0] dest,
    input logic [DW-1:0] wd, idx, input logic [AW-1:0] base, stride,
    input int unsigned rdy_dly, resp_dly, input logic [DW-1:0] rdata,
    input logic [AW-1:0] exp_addr, input logic exp_we, exp_perr);
    vec_t v;
    v.ld = ld; v.st = st; v.idx_op = idx_op; v.dest = dest;
    v.wd = wd; v.idx = idx; v.base = base; v.stride = stride;
    v.rdy_dly = rdy_dly; v.resp_dly = resp_dly; v.rdata = rdata;
    v.exp_addr = exp_addr; v.exp_we = exp_we; v.exp_perr = exp_perr;
    return v;
  endfunction

  vec_t table_v[6];

  initial begin
    vec_t v;
    logic [AW-1:0] off;

    //                  ld st ix dest wd                      idx                     base          stride     rdy resp rdata                   exp_addr      we perr
    table_v[0] = mkvec(1, 0, 0, 5'd3,  64'h0,                 64'h0,                  32'h0000_1000, 32'h8,     0,  0,  64'hDEAD_BEEF_CAFE_F00D, 32'h0000_1008, 0, 0);
    table_v[1] = mkvec(0, 1, 0, 5'd7,  64'h1234,              64'h0,                  32'h0000_2000, 32'h10,    4,  0,  64'h0,                  32'h0000_2010, 1, 0);
    table_v[2] = mkvec(1, 0, 1, 5'd9,  64'hFFFF,              64'h5555_5555_0000_0020, 32'hFFFF_FFF0, 32'h4,     1,  3,  64'h0123_4567_89AB_CDEF, 32'h0000_0010, 0, 0);
    table_v[3] = mkvec(0, 1, 1, 5'd1,  64'hA5A5_0000_0000_5A5A, 64'h0000_0000_0000_0100, 32'h0000_4000, 32'h999,   2,  0,  64'h0,                  32'h0000_4100, 1, 0);
    table_v[4] = mkvec(1, 1, 0, 5'd31, 64'hBAD0_BAD0_BAD0_BAD0, 64'h0,                 32'h0000_8000, 32'h40,    0,  1,  64'hFEED_FACE_0000_0001, 32'h0000_8040, 0, 1);
    table_v[5] = mkvec(0, 1, 0, 5'd2,  64'h0000_0000_0000_00C3, 64'h0,                 32'h0000_9000, 32'h0,     0,  0,  64'h0,                  32'h0000_9000, 1, 1);

    rst = 1'b1;
    ld_valid = 1'b0; st_valid = 1'b0; indexed_op = 1'b0; ld_destination = '0;
    wrdata = '0; indexed = '0; base_addr = '0; stride_offset = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    tick();
    tick();
    check_quiet("reset", 1'b0);
    check("reset req_addr", DW'(mem_req_addr), '0);
    check("reset req_wdata", mem_req_wdata, '0);
    rst = 1'b0;
    tick();
    check_quiet("after reset", 1'b0);

    for (int i = 0; i < 6; i++) do_op(table_v[i], 0);
    m_perr = 1'b1;

    // Reset during RESP: abort at once, late response ignored, sticky error cleared.
    ld_valid = 1'b1; base_addr = 32'h100; stride_offset = 32'h4; ld_destination = 5'd6;
    tick();
    ld_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("pre-abort busy", DW'(busy), 1);
    rst = 1'b1;
    #1;
    check_quiet("abort", 1'b0);
    check("abort req_addr", DW'(mem_req_addr), '0);
    m_perr = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = {$urandom, $urandom};
      tick();
      check_quiet("late resp", 1'b0);
    end
    mem_resp_valid = 1'b0;

    // Load with ld/st held high throughout busy: no second request, no error.
    v = mkvec(1, 0, 0, 5'd12, 64'h0, 64'h0, 32'h0000_3000, 32'h18, 1, 2,
              64'h1111_2222_3333_4444, 32'h0000_3018, 0, 0);
    do_op(v, 1);
    tick();
    check_quiet("no 2nd req", 1'b0);

    // Stray response in IDLE after a completed op.
    for (int i = 0; i < 2; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 64'hCCCC_DDDD_EEEE_FFFF;
      tick();
      check_quiet("stray resp", 1'b0);
    end
    mem_resp_valid = 1'b0;

    // Randomized operations against the transaction model.
    for (int n = 0; n < 60; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 9);
      v.ld = (kind < 4) || (kind == 9);
      v.st = (kind >= 4);
      v.idx_op = 1'($urandom);
      v.dest = 5'($urandom);
      v.wd = {$urandom, $urandom};
      v.idx = {$urandom, $urandom};
      v.base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255)) : $urandom;
      v.stride = $urandom;
      v.rdy_dly = $urandom_range(0, 3);
      v.resp_dly = $urandom_range(0, 3);
      v.rdata = {$urandom, $urandom};
      off = v.idx_op ? v.idx[AW-1:0] : v.stride;
      v.exp_addr = v.base + off;
      v.exp_we = v.st && !v.ld;
      if (v.ld && v.st) m_perr = 1'b1;
      v.exp_perr = m_perr;
      do_op(v, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vlane_mem_unit.md
# vlane_mem_unit

Per-lane vector load/store unit, directly downstream of the lane issue stage. It accepts one load or store per instruction and computes the lane address as a base plus either a stride offset or a per-element index. It performs a single valid/ready request and response transaction on the lane memory port. Load data is returned through the `read_done` / `load_data_destination` / `data_from_load` write-back path into the lane vector register file.

## Interface
- `LANES_DATA_WIDTH`, default 64: lane data width, and width of store data and index operand.
- `ADDR_WIDTH`, default 32: memory address width. Must satisfy `ADDR_WIDTH <= LANES_DATA_WIDTH`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `ld_valid`  in  1  load request from issue (its `wait_load_signal`).
- `st_valid`  in  1  store request from issue.
- `indexed_op`  in  1  use `indexed` as the address offset.
- `ld_destination`  in  5  destination vector register of the load.
- `wrdata`  in  `LANES_DATA_WIDTH`  store data.
- `indexed`  in  `LANES_DATA_WIDTH`  index operand.
- `base_addr`  in  `ADDR_WIDTH`  scalar base address.
- `stride_offset`  in  `ADDR_WIDTH`  lane offset for unit-stride and strided access.
- `busy`  out  1  unit not IDLE; issue must hold off new memory operations.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_we`  out  1  1 = store.
- `mem_req_addr`  out  `ADDR_WIDTH`  request address.
- `mem_req_wdata`  out  `LANES_DATA_WIDTH`  store data.
- `mem_resp_valid`  in  1  load response valid.
- `mem_resp_rdata`  in  `LANES_DATA_WIDTH`  load response data.
- `read_done`  out  1  one-cycle VRF write strobe for load data.
- `load_data_destination`  out  5  VRF write address.
- `data_from_load`  out  `LANES_DATA_WIDTH`  VRF write data.
- `st_done`  out  1  one-cycle store-complete pulse.
- `protocol_err`  out  1  sticky flag: `ld_valid` and `st_valid` were asserted together.

## Operation
- FSM states: IDLE, REQ, RESP, WB, SDONE.
- **IDLE**
  - `ld_valid` or `st_valid` → capture request → REQ.
  - Captured fields: `we`, `addr = base_addr + (indexed_op ? indexed[ADDR_WIDTH-1:0] : stride_offset)` (modulo 2^`ADDR_WIDTH`, carry dropped), `wrdata`, `ld_destination`.
  - `ld_valid` and `st_valid` together → treated as a load and `protocol_err` is set; it is cleared only by `rst`.
- **REQ**
  - `mem_req_valid` = 1; `mem_req_addr`, `mem_req_we` and `mem_req_wdata` are held stable from registers.
  - Waits indefinitely for `mem_req_ready`.
  - On handshake: store → SDONE, load → RESP.
- **RESP**
  - Waits for `mem_resp_valid`, then captures `mem_resp_rdata` → WB.
- **WB**
  - `read_done` = 1, `load_data_destination` = captured destination, `data_from_load` = captured data → IDLE.
- **SDONE**
  - `st_done` = 1 → IDLE.
- `busy` = (state != IDLE).
- `ld_valid` and `st_valid` are ignored while busy.
- `mem_resp_valid` outside RESP is ignored.
- `mem_req_wdata` is 0 for loads.
- `data_from_load` and `load_data_destination` are 0 whenever `read_done` = 0.

## Timing
- Reset values: state IDLE; every output 0.
- Reset mid-operation aborts the transaction immediately:
  - pending request is dropped;
  - a later `mem_resp_valid` is ignored;
  - no `read_done` or `st_done` is issued.
- Capture happens on cycle T; `mem_req_valid` rises on cycle T+1.
- With `mem_req_ready` = 1 at T+1:
  - store: `st_done` at T+2;
  - load with response at T+2: `read_done` at T+3.
- General load latency: `read_done` is asserted exactly 1 cycle after the `mem_resp_valid` cycle.
- Back-to-back operations: the earliest next capture is the cycle after WB or SDONE, when `busy` = 0.
- All outputs are registered or decoded from state only. There is no combinational path from `mem_req_ready` or `mem_resp_valid` to any output.

## Structure
- The state enum `vmu_state_e` and a `vmu_req_t` struct (`we`, `addr`, `wdata`, `dest`) go in the shared vector package alongside `to_vector_execution`.
- One sub-module is natural: `vmu_agu`, the combinational address adder and offset-select mux, parameterised by `ADDR_WIDTH`.

## Test plan
- **Unit-stride load:** base=0x1000, stride_offset=0x8, ld_destination=3; ready=1; response 0xDEADBEEF_CAFEF00D one cycle after handshake.
  - `mem_req_addr` = 0x1008, `we` = 0;
  - `read_done` at T+3 with destination 3 and that data.
- **Store with 4-cycle ready stall:** wrdata=0x1234.
  - `mem_req_valid` held high with stable address and data for 4 cycles;
  - `st_done` 1 cycle after the handshake;
  - `busy` high throughout.
- **Indexed load with address wrap:** base=0xFFFF_FFF0, indexed=0x20.
  - `mem_req_addr` = 0x0000_0010.
- **Simultaneous `ld_valid` and `st_valid`:**
  - load performed;
  - `protocol_err` = 1 and still 1 after a subsequent clean store.
- **Request while busy, plus stray response:**
  - `st_valid` pulse during RESP is ignored, with no second request;
  - `mem_resp_valid` while in IDLE produces no `read_done`.
- **Reset during RESP:**
  - all outputs 0 and `busy` = 0 on the same cycle;
  - a late `mem_resp_valid` after reset produces no `read_done`.
